wdt_timer: RTL

WDT_TIMER -- requirements
Module: wdt_timer

---
 rtl/wdt_timer.sv | 113 +++++++++++
 1 files changed

// File: rtl/wdt_timer.sv
// ============================================================================
//  Module   : wdt_timer
//  Purpose  : Watchdog timer with a kick register and a level timeout output.
//  Options  : define WDT_PRESCALE_EN to count 2**PRESCALE-cycle ticks.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wdt_timer #(
   parameter int CNT_W    = 32,
   parameter int PRESCALE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [1:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        timeout
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COUNT   = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   localparam logic [1:0] c_addr_wden   = 2'd0;
   localparam logic [1:0] c_addr_wdlive = 2'd1;
   localparam logic [1:0] c_addr_wtocnt = 2'd2;

   state_t           r_state;
   logic             r_wden;
   logic [CNT_W-1:0] r_wtocnt;
   logic [CNT_W-1:0] r_cnt;
   logic             r_timeout;

   logic w_wr_wden;
   logic w_wr_wtocnt;
   logic w_kick;
   logic w_tick;

   assign w_wr_wden   = wr_en && (addr == c_addr_wden);
   assign w_wr_wtocnt = wr_en && (addr == c_addr_wtocnt);
   assign w_kick      = wr_en && (addr == c_addr_wdlive) && wr_data[0]
                        && (r_state != ST_IDLE);

`ifdef WDT_PRESCALE_EN
   logic [PRESCALE-1:0] r_presc;

   assign w_tick = &r_presc;

   always_ff @(posedge clk) begin
      if (rst || w_wr_wden || w_kick) begin
         r_presc <= '0;
      end else if (r_state == ST_COUNT) begin
         r_presc <= r_presc + 1'b1;
      end
   end
`else
   localparam int c_unused_prescale = PRESCALE;

   assign w_tick = 1'b1;
`endif

   // Priority: reset, then WDEN write, then kick, then normal counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_wden    <= 1'b0;
         r_wtocnt  <= '1;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_wr_wtocnt) begin
            r_wtocnt <= wr_data[CNT_W-1:0];
         end
         if (w_wr_wden) begin
            r_wden    <= wr_data[0];
            r_state   <= wr_data[0] ? ST_COUNT : ST_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
         end else if (w_kick) begin
            r_state   <= ST_COUNT;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
         end else if (r_state == ST_COUNT && w_tick) begin
            // The threshold compare uses the value held before any same-cycle write.
            if (r_cnt >= r_wtocnt) begin
               r_state   <= ST_EXPIRED;
               r_timeout <= 1'b1;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      rd_data = 32'd0;
      case (addr)
         2'd0:    rd_data = {31'd0, r_wden};
         2'd1:    rd_data = 32'd0;
         2'd2:    rd_data = 32'(r_wtocnt);
         default: rd_data = 32'(r_cnt);
      endcase
   end

   assign timeout = r_timeout;

endmodule

`default_nettype wire
